// File: rtl/conv_pkg.sv
// Shared types and saturation helper for the convolution layer scheduler.
package conv_pkg;

   localparam int unsigned RES_W_C = 18;
   localparam int unsigned ACC_W_C = 24;

   localparam logic signed [ACC_W_C-1:0] RES_MAX = ACC_W_C'((2 ** (RES_W_C - 1)) - 1);
   localparam logic signed [ACC_W_C-1:0] RES_MIN = -ACC_W_C'(2 ** (RES_W_C - 1));

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ISSUE,
      WAIT,
      ACCUM,
      EMIT,
      DONE
   } state_t;

   function automatic logic [RES_W_C-1:0] sat_res(input logic signed [ACC_W_C-1:0] acc);
      logic [RES_W_C-1:0] r;
      if (acc > RES_MAX) begin
         r = RES_MAX[RES_W_C-1:0];
      end else if (acc < RES_MIN) begin
         r = RES_MIN[RES_W_C-1:0];
      end else begin
         r = acc[RES_W_C-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Nested group/column/row counter; one step advances the innermost group index.
module conv_pos_counter #(
   parameter int unsigned ROW_W = 8,
   parameter int unsigned COL_W = 8,
   parameter int unsigned GRP_W = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic             i_step,
   input  logic [ROW_W-1:0] i_rows,
   input  logic [COL_W-1:0] i_cols,
   input  logic [GRP_W-1:0] i_grps,
   output logic [ROW_W-1:0] o_row,
   output logic [COL_W-1:0] o_col,
   output logic [GRP_W-1:0] o_grp,
   output logic             o_last_grp,
   output logic             o_last_pos
);

   logic [ROW_W-1:0] r_row, w_row_d;
   logic [COL_W-1:0] r_col, w_col_d;
   logic [GRP_W-1:0] r_grp, w_grp_d;
   logic             w_last_col, w_last_row;

   assign o_last_grp = (r_grp == i_grps - GRP_W'(1));
   assign w_last_col = (r_col == i_cols - COL_W'(1));
   assign w_last_row = (r_row == i_rows - ROW_W'(1));
   assign o_last_pos = w_last_col && w_last_row;

   always_comb begin
      w_row_d = r_row;
      w_col_d = r_col;
      w_grp_d = r_grp;
      if (i_clr) begin
         w_row_d = '0;
         w_col_d = '0;
         w_grp_d = '0;
      end else if (i_step) begin
         if (!o_last_grp) begin
            w_grp_d = r_grp + GRP_W'(1);
         end else begin
            w_grp_d = '0;
            if (!w_last_col) begin
               w_col_d = r_col + COL_W'(1);
            end else begin
               w_col_d = '0;
               w_row_d = w_last_row ? '0 : r_row + ROW_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_row <= '0;
         r_col <= '0;
         r_grp <= '0;
      end else begin
         r_row <= w_row_d;
         r_col <= w_col_d;
         r_grp <= w_grp_d;
      end
   end

   assign o_row = r_row;
   assign o_col = r_col;
   assign o_grp = r_grp;

endmodule

// File: rtl/conv_sched.sv
// Sequences one convolution layer: window fetch, mac_array issue, group accumulation
// and output pixel emission, one window outstanding at a time.
module conv_sched
   import conv_pkg::*;
#(
   parameter int unsigned ROW_W = 8,
   parameter int unsigned COL_W = 8,
   parameter int unsigned GRP_W = 6,
   parameter int unsigned RES_W = RES_W_C,
   parameter int unsigned ACC_W = ACC_W_C
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cfg_rcv_l2,
   input  logic [ROW_W-1:0] cfg_rows,
   input  logic [COL_W-1:0] cfg_cols,
   input  logic [GRP_W-1:0] cfg_grps,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic             win_req_o,
   output logic [ROW_W-1:0] win_row_o,
   output logic [COL_W-1:0] win_col_o,
   output logic [GRP_W-1:0] win_grp_o,
   input  logic             win_ack_i,
   output logic             mac_rcv_l2_o,
   output logic             mac_valid_o,
   input  logic             mac_ready_i,
   input  logic             mac_valid_i,
   input  logic [RES_W-1:0] mac_res_i,
   output logic             ofm_valid_o,
   input  logic             ofm_ready_i,
   output logic [ROW_W-1:0] ofm_row_o,
   output logic [COL_W-1:0] ofm_col_o,
   output logic [RES_W-1:0] ofm_data_o
);

   state_t                  r_state, w_state_d;
   logic                    r_rcv_l2;
   logic [ROW_W-1:0]        r_rows;
   logic [COL_W-1:0]        r_cols;
   logic [GRP_W-1:0]        r_grps;
   logic                    r_busy, r_done, r_err, r_win_req, r_mac_valid, r_ofm_valid;
   logic [RES_W-1:0]        r_res;
   logic [RES_W-1:0]        r_ofm_data;
   logic signed [ACC_W-1:0] r_acc, w_acc_d, w_res_ext;
   logic                    w_accept, w_step, w_empty;
   logic [ROW_W-1:0]        w_row;
   logic [COL_W-1:0]        w_col;
   logic [GRP_W-1:0]        w_grp;
   logic                    w_last_grp, w_last_pos;

   conv_pos_counter #(
      .ROW_W(ROW_W),
      .COL_W(COL_W),
      .GRP_W(GRP_W)
   ) u_pos (
      .i_clk     (clk),
      .i_rst_n   (rst),
      .i_clr     (w_accept),
      .i_step    (w_step),
      .i_rows    (r_rows),
      .i_cols    (r_cols),
      .i_grps    (r_grps),
      .o_row     (w_row),
      .o_col     (w_col),
      .o_grp     (w_grp),
      .o_last_grp(w_last_grp),
      .o_last_pos(w_last_pos)
   );

   assign w_empty   = (cfg_rows == '0) || (cfg_cols == '0);
   assign w_res_ext = {{(ACC_W - RES_W){r_res[RES_W-1]}}, r_res};
   // Group 0 restarts the sum; in layer-2 mode every step is group 0.
   assign w_acc_d   = ((w_grp == '0) ? '0 : r_acc) + w_res_ext;

   always_comb begin
      w_state_d = r_state;
      w_accept  = 1'b0;
      w_step    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept  = 1'b1;
               w_state_d = w_empty ? DONE : FETCH;
            end
         end
         FETCH: if (win_ack_i) w_state_d = ISSUE;
         ISSUE: if (mac_ready_i) w_state_d = WAIT;
         WAIT:  if (mac_valid_i) w_state_d = ACCUM;
         ACCUM: begin
            w_step    = !w_last_grp;
            w_state_d = w_last_grp ? EMIT : FETCH;
         end
         EMIT: begin
            if (ofm_ready_i) begin
               w_step    = 1'b1;
               w_state_d = w_last_pos ? DONE : FETCH;
            end
         end
         DONE:    w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_rcv_l2    <= 1'b0;
         r_rows      <= '0;
         r_cols      <= '0;
         r_grps      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_win_req   <= 1'b0;
         r_mac_valid <= 1'b0;
         r_ofm_valid <= 1'b0;
         r_res       <= '0;
         r_acc       <= '0;
         r_ofm_data  <= '0;
      end else begin
         r_state     <= w_state_d;
         r_busy      <= (w_state_d != IDLE);
         r_done      <= (r_state == DONE);
         r_win_req   <= (w_state_d == FETCH);
         r_mac_valid <= (w_state_d == ISSUE);
         r_ofm_valid <= (w_state_d == EMIT);
         if (w_accept) begin
            r_rcv_l2 <= cfg_rcv_l2;
            r_rows   <= cfg_rows;
            r_cols   <= cfg_cols;
            r_grps   <= (cfg_rcv_l2 || (cfg_grps == '0)) ? GRP_W'(1) : cfg_grps;
            r_err    <= 1'b0;
         end else if (mac_valid_i && (r_state != IDLE) && (r_state != WAIT)) begin
            r_err <= 1'b1;
         end
         if ((r_state == WAIT) && mac_valid_i) begin
            r_res <= mac_res_i;
         end
         if (r_state == ACCUM) begin
            r_acc <= w_acc_d;
            if (w_last_grp) r_ofm_data <= sat_res(w_acc_d);
         end
      end
   end

   assign busy_o       = r_busy;
   assign done_o       = r_done;
   assign err_o        = r_err;
   assign win_req_o    = r_win_req;
   assign win_row_o    = w_row;
   assign win_col_o    = w_col;
   assign win_grp_o    = w_grp;
   assign mac_rcv_l2_o = r_rcv_l2;
   assign mac_valid_o  = r_mac_valid;
   assign ofm_valid_o  = r_ofm_valid;
   assign ofm_row_o    = w_row;
   assign ofm_col_o    = w_col;
   assign ofm_data_o   = r_ofm_data;

endmodule

// File: tb/tb_conv_sched.sv
// Scoreboard bench for conv_sched: stimulus queues expected windows/pixels, monitor checks them.
module tb_conv_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        cfg_rcv_l2 = 1'b0;
   logic [7:0]  cfg_rows = '0;
   logic [7:0]  cfg_cols = '0;
   logic [5:0]  cfg_grps = '0;
   logic        busy_o, done_o, err_o, win_req_o, mac_rcv_l2_o, mac_valid_o, ofm_valid_o;
   logic [7:0]  win_row_o, win_col_o, ofm_row_o, ofm_col_o;
   logic [5:0]  win_grp_o;
   logic [17:0] ofm_data_o;
   logic        win_ack_i = 1'b0;
   logic        mac_ready_i = 1'b1;
   logic        mac_valid_i;
   logic [17:0] mac_res_i = '0;
   logic        ofm_ready_i = 1'b1;

   logic        model_mv = 1'b0;
   logic        inj_mv = 1'b0;
   logic        ack_en = 1'b1;
   int          mac_cnt = 0;

   typedef struct {int row; int col; int grp;} win_t;
   typedef struct {int row; int col; int data;} pix_t;
   win_t win_q[$];
   pix_t pix_q[$];
   int   res_q[$];

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   logic prev_req = 1'b0;
   logic prev_ofm = 1'b0;

   assign mac_valid_i = model_mv | inj_mv;

   conv_sched dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .cfg_rcv_l2  (cfg_rcv_l2),
      .cfg_rows    (cfg_rows),
      .cfg_cols    (cfg_cols),
      .cfg_grps    (cfg_grps),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .win_req_o   (win_req_o),
      .win_row_o   (win_row_o),
      .win_col_o   (win_col_o),
      .win_grp_o   (win_grp_o),
      .win_ack_i   (win_ack_i),
      .mac_rcv_l2_o(mac_rcv_l2_o),
      .mac_valid_o (mac_valid_o),
      .mac_ready_i (mac_ready_i),
      .mac_valid_i (mac_valid_i),
      .mac_res_i   (mac_res_i),
      .ofm_valid_o (ofm_valid_o),
      .ofm_ready_i (ofm_ready_i),
      .ofm_row_o   (ofm_row_o),
      .ofm_col_o   (ofm_col_o),
      .ofm_data_o  (ofm_data_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic note_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got event/timeout expected none", name);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_win(input int r, input int c, input int g);
      win_t w;
      w.row = r; w.col = c; w.grp = g;
      win_q.push_back(w);
   endtask

   task automatic push_pix(input int r, input int c, input int d);
      pix_t p;
      p.row = r; p.col = c; p.data = d;
      pix_q.push_back(p);
   endtask

   // Leaves the caller at the negedge of the cycle after start was sampled.
   task automatic pulse_start(input logic l2, input int rows, input int cols, input int grps);
      tick();
      start = 1'b1; cfg_rcv_l2 = l2;
      cfg_rows = 8'(rows); cfg_cols = 8'(cols); cfg_grps = 6'(grps);
      tick();
      start = 1'b0; cfg_rcv_l2 = ~l2;
      cfg_rows = 8'hA5; cfg_cols = 8'h5A; cfg_grps = 6'h2B;
   endtask

   task automatic wait_done(input string name);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < 400) begin
         tick();
         n++;
      end
      if (done_cnt == d0) note_fail(name);
   endtask

   function automatic longint out_vec();
      return longint'({busy_o, done_o, err_o, win_req_o, win_row_o, win_col_o, win_grp_o,
                       mac_rcv_l2_o, mac_valid_o, ofm_valid_o, ofm_row_o, ofm_col_o, ofm_data_o});
   endfunction

   // Window buffer and mac_array model: ack on request, result 3 cycles after issue.
   always @(negedge clk) begin
      win_ack_i = win_req_o & ack_en;
      model_mv = 1'b0;
      if (mac_cnt > 0) begin
         mac_cnt--;
         if (mac_cnt == 0) begin
            model_mv = 1'b1;
            if (res_q.size() > 0) mac_res_i = 18'(res_q.pop_front());
            else mac_res_i = '0;
         end
      end else if (mac_valid_o && mac_ready_i) begin
         mac_cnt = 3;
      end
   end

   always @(negedge clk) begin
      win_t w;
      pix_t p;
      if (rst) begin
         if (win_req_o && !prev_req) begin
            if (win_q.size() == 0) begin
               note_fail("win_unexpected");
            end else begin
               w = win_q.pop_front();
               chk("win_row", longint'(win_row_o), w.row);
               chk("win_col", longint'(win_col_o), w.col);
               chk("win_grp", longint'(win_grp_o), w.grp);
            end
         end
         if (ofm_valid_o && !prev_ofm) begin
            if (pix_q.size() == 0) begin
               note_fail("ofm_unexpected");
            end else begin
               p = pix_q.pop_front();
               chk("ofm_row", longint'(ofm_row_o), p.row);
               chk("ofm_col", longint'(ofm_col_o), p.col);
               chk("ofm_data", longint'($signed(ofm_data_o)), p.data);
            end
         end
         if (done_o) done_cnt++;
      end
      prev_req = win_req_o;
      prev_ofm = ofm_valid_o;
   end

   initial begin
      int d0;
      int n;
      logic [7:0]  s_row, s_col;
      logic [17:0] s_data;

      repeat (3) tick();
      chk("reset_outputs", out_vec(), 0);
      rst = 1'b1;
      tick();

      // 1: layer-2 mode 2x2, grps forced to 1
      res_q.push_back(10); res_q.push_back(20); res_q.push_back(-30); res_q.push_back(40);
      push_win(0, 0, 0); push_win(0, 1, 0); push_win(1, 0, 0); push_win(1, 1, 0);
      push_pix(0, 0, 10); push_pix(0, 1, 20); push_pix(1, 0, -30); push_pix(1, 1, 40);
      d0 = done_cnt;
      pulse_start(1'b1, 2, 2, 5);
      chk("t1_req_next_cycle", win_req_o, 1);
      chk("t1_busy", busy_o, 1);
      chk("t1_rcv_l2", mac_rcv_l2_o, 1);
      wait_done("t1_done_timeout");
      repeat (3) tick();
      chk("t1_done_count", done_cnt - d0, 1);
      chk("t1_busy_end", busy_o, 0);
      chk("t1_win_q_left", win_q.size(), 0);
      chk("t1_pix_q_left", pix_q.size(), 0);

      // 2: deep mode, three groups accumulated
      res_q.push_back(100); res_q.push_back(-30); res_q.push_back(5);
      push_win(0, 0, 0); push_win(0, 0, 1); push_win(0, 0, 2);
      push_pix(0, 0, 75);
      pulse_start(1'b0, 1, 1, 3);
      chk("t2_rcv_l2", mac_rcv_l2_o, 0);
      wait_done("t2_done_timeout");
      chk("t2_pix_q_left", pix_q.size(), 0);

      // 3: saturation at both ends
      res_q.push_back(131071); res_q.push_back(131071);
      push_win(0, 0, 0); push_win(0, 0, 1);
      push_pix(0, 0, 131071);
      pulse_start(1'b0, 1, 1, 2);
      wait_done("t3a_done_timeout");
      res_q.push_back(-131072); res_q.push_back(-131072);
      push_win(0, 0, 0); push_win(0, 0, 1);
      push_pix(0, 0, -131072);
      pulse_start(1'b0, 1, 1, 2);
      wait_done("t3b_done_timeout");
      chk("t3_pix_q_left", pix_q.size(), 0);

      // 4: ofmap writer stalls for 5 cycles
      ofm_ready_i = 1'b0;
      res_q.push_back(7); res_q.push_back(9);
      push_win(0, 0, 0); push_win(0, 1, 0);
      push_pix(0, 0, 7); push_pix(0, 1, 9);
      pulse_start(1'b0, 1, 2, 1);
      n = 0;
      while (!ofm_valid_o && n < 100) begin
         tick();
         n++;
      end
      if (!ofm_valid_o) begin
         note_fail("t4_emit_timeout");
      end else begin
         s_row = ofm_row_o; s_col = ofm_col_o; s_data = ofm_data_o;
         for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_valid_held", ofm_valid_o, 1);
            chk("t4_row_held", ofm_row_o, s_row);
            chk("t4_col_held", ofm_col_o, s_col);
            chk("t4_data_held", ofm_data_o, s_data);
            chk("t4_no_req", win_req_o, 0);
         end
      end
      ofm_ready_i = 1'b1;
      wait_done("t4_done_timeout");
      chk("t4_pix_q_left", pix_q.size(), 0);

      // 5: reset while waiting for mac result
      res_q.push_back(55);
      push_win(0, 0, 0);
      d0 = done_cnt;
      pulse_start(1'b0, 1, 1, 1);
      n = 0;
      while (!mac_valid_o && n < 50) begin
         tick();
         n++;
      end
      while (mac_valid_o && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) note_fail("t5_wait_timeout");
      rst = 1'b0;
      tick();
      chk("t5_reset_outputs", out_vec(), 0);
      rst = 1'b1;
      repeat (5) tick();
      chk("t5_err_after_late_valid", err_o, 0);
      chk("t5_busy", busy_o, 0);
      chk("t5_no_done", done_cnt - d0, 0);
      chk("t5_res_consumed", res_q.size(), 0);

      // 6: stray mac valid in FETCH, start while busy, error cleared by next start
      ack_en = 1'b0;
      res_q.push_back(12);
      push_win(0, 0, 0);
      push_pix(0, 0, 12);
      d0 = done_cnt;
      pulse_start(1'b0, 1, 1, 1);
      chk("t6_fetch_req", win_req_o, 1);
      inj_mv = 1'b1;
      tick();
      inj_mv = 1'b0;
      chk("t6_err_set", err_o, 1);
      pulse_start(1'b0, 3, 3, 1);
      chk("t6_err_kept", err_o, 1);
      ack_en = 1'b1;
      wait_done("t6_done_timeout");
      chk("t6_err_sticky", err_o, 1);
      repeat (2) tick();
      chk("t6_done_count", done_cnt - d0, 1);
      chk("t6_win_q_left", win_q.size(), 0);
      res_q.push_back(3);
      push_win(0, 0, 0);
      push_pix(0, 0, 3);
      pulse_start(1'b1, 1, 1, 1);
      chk("t6_err_cleared", err_o, 0);
      wait_done("t6b_done_timeout");
      chk("t6_pix_q_left", pix_q.size(), 0);

      // 7: empty layer finishes without requests
      d0 = done_cnt;
      pulse_start(1'b0, 0, 3, 2);
      chk("t7_busy", busy_o, 1);
      chk("t7_no_req", win_req_o, 0);
      chk("t7_done_early", done_o, 0);
      tick();
      chk("t7_done_t2", done_o, 1);
      tick();
      chk("t7_done_pulse", done_o, 0);
      chk("t7_idle", busy_o, 0);
      chk("t7_done_count", done_cnt - d0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
